div_ctrl: RTL and testbench

- Multi-cycle iterative divider and sequencer for the EX stage. Executes DIV/DIVU issued by the decoder.
- Latches operands, runs a radix-2 restoring division over WIDTH cycles and stalls the pipeline while busy.
- Presents the result as {HI = remainder, LO = quotient} for the HI/LO register write.
- Honours a pipeline flush (exception or ERET) at any time.

---
 rtl/div_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_div_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle radix-2 restoring divider and sequencer for the EX stage.
// Executes DIV/DIVU and stalls the front of the pipeline while it runs.
// Result is presented as {HI = remainder, LO = quotient} for the HI/LO write.
// A flush cancels any operation in flight. Divide by zero bypasses the iteration
// and returns LO = all ones, HI = dividend.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             flush_i,
    input  logic             ack_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    // Counter only has to reach WIDTH-1; the final step wraps it back to zero.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Control strobes decoded from the current state and inputs.
    logic w_load;
    logic w_dbz;
    logic w_step;
    logic w_last;

    // Iteration state: partial remainder, dividend/quotient shifter, divisor magnitude.
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_qneg;
    logic             r_rneg;
    logic [CW-1:0]    r_cnt;

    // Registered result, held across DONE and after the acknowledge.
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // One restoring step, computed combinationally from the iteration registers.
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    // Two's-complement magnitude of an operand; unsigned operands pass through.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    // Re-applies the sign latched at start to an unsigned quotient or remainder.
    // The most negative dividend divided by -1 wraps naturally here.
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic             neg);
        return neg ? -v : v;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and datapath strobes; flush overrides start and ack.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dbz       = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        if (flush_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (opb_i == '0) begin
                            w_dbz       = 1'b1;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_load      = 1'b1;
                            w_state_nxt = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    w_step = 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    if (ack_i) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Restoring step: shift {rem, quo} left, trial-subtract the divisor in
    // WIDTH+1 bits and keep the difference when it is non-negative.
    always_comb begin
        w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
        w_trial   = w_rem_sh - {1'b0, r_dvs};
        w_rem_nxt = w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
        w_quo_nxt = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
    end

    // Iteration counter: cleared on flush, on load and after the final step.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (flush_i || w_load || w_last) begin
            r_cnt <= '0;
        end else if (w_step) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Operand latch and iteration registers; operands are only sampled in IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
        end else if (w_load) begin
            r_rem  <= '0;
            r_quo  <= magnitude(opa_i, signed_i);
            r_dvs  <= magnitude(opb_i, signed_i);
            r_qneg <= signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
            r_rneg <= signed_i & opa_i[WIDTH-1];
        end else if (w_step) begin
            r_rem  <= w_rem_nxt;
            r_quo  <= w_quo_nxt;
        end
    end

    // Result registers: written once on entry to DONE, otherwise held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_dbz) begin
            r_hi <= opa_i;
            r_lo <= '1;
        end else if (w_last) begin
            r_hi <= apply_sign(w_rem_nxt, r_rneg);
            r_lo <= apply_sign(w_quo_nxt, r_qneg);
        end
    end

    // Status outputs; the stall drops in the same cycle the result becomes valid.
    always_comb begin
        busy_o  = (r_state == S_BUSY);
        valid_o = (r_state == S_DONE);
        stall_o = start_i & ~valid_o;
        hi_o    = r_hi;
        lo_o    = r_lo;
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed and randomized checks of div_ctrl against an
// arithmetic reference model (plain / and % on 64-bit values).
module tb_div_ctrl;

    localparam int W = 32;

    logic         clk;
    logic         resetn;
    logic         start_i;
    logic         signed_i;
    logic [W-1:0] opa_i;
    logic [W-1:0] opb_i;
    logic         flush_i;
    logic         ack_i;
    logic         stall_o;
    logic         busy_o;
    logic         valid_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    int vectors = 0;
    int miscmp  = 0;

    div_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (start_i),
        .signed_i (signed_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .flush_i  (flush_i),
        .ack_i    (ack_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: quotient/remainder from plain arithmetic, truncating division.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input bit s, output logic [W-1:0] q,
                                  output logic [W-1:0] r);
        longint sa;
        longint sb;
        longint sq;
        longint sr;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[W-1:0];
            r  = sr[W-1:0];
        end
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide just after an edge, wait for valid, check latency and
    // result, optionally hold without ack, then acknowledge.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                          input bit scramble, input int hold, input string tag);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int n;
        int lat;
        model(a, b, s, eq, er);
        lat      = (b == 0) ? 1 : W + 1;
        start_i  = 1'b1;
        signed_i = s;
        opa_i    = a;
        opb_i    = b;
        #1;
        check1({tag, ".stall_start"}, stall_o, 1'b1);
        n = 0;
        while (!valid_o && n < 100) begin
            step();
            n++;
            if (n == 1 && b != 0) check1({tag, ".busy"}, busy_o, 1'b1);
            if (scramble && n == 5) begin
                opa_i    = $urandom;
                opb_i    = $urandom;
                signed_i = ~s;
            end
        end
        check({tag, ".latency"}, n, lat);
        check({tag, ".lo"}, lo_o, eq);
        check({tag, ".hi"}, hi_o, er);
        check1({tag, ".stall_done"}, stall_o, 1'b0);
        for (int k = 0; k < hold; k++) begin
            step();
            check1({tag, ".hold_valid"}, valid_o, 1'b1);
            check({tag, ".hold_lo"}, lo_o, eq);
            check({tag, ".hold_hi"}, hi_o, er);
        end
        start_i = 1'b0;
        ack_i   = 1'b1;
        step();
        ack_i   = 1'b0;
        check1({tag, ".ack_valid"}, valid_o, 1'b0);
        check1({tag, ".ack_busy"}, busy_o, 1'b0);
        check({tag, ".ack_lo_kept"}, lo_o, eq);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           rs;
        bit           seen;
        int           sel;

        resetn   = 1'b0;
        start_i  = 1'b0;
        signed_i = 1'b0;
        opa_i    = '0;
        opb_i    = '0;
        flush_i  = 1'b0;
        ack_i    = 1'b0;
        repeat (3) step();
        check1("rst.busy", busy_o, 1'b0);
        check1("rst.valid", valid_o, 1'b0);
        check1("rst.stall", stall_o, 1'b0);
        check("rst.hi", hi_o, '0);
        check("rst.lo", lo_o, '0);
        resetn = 1'b1;
        step();

        // Directed cases.
        do_div(32'd100, 32'd7, 1'b0, 1'b0, 0, "divu_100_7");
        do_div(32'hFFFF_FFF9, 32'h2, 1'b1, 1'b0, 0, "div_m7_2");
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, "div_ovf");
        do_div(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 0, "divu_max_1");
        do_div(32'h1234, 32'h0, 1'b0, 1'b0, 0, "divu_dbz");
        do_div(32'h1234, 32'h0, 1'b1, 1'b0, 0, "div_dbz");

        // Flush in BUSY cycle 10: back to IDLE, no result.
        start_i  = 1'b1;
        signed_i = 1'b1;
        opa_i    = 32'd1000;
        opb_i    = 32'd3;
        repeat (10) step();
        check1("flush.busy_before", busy_o, 1'b1);
        flush_i = 1'b1;
        start_i = 1'b0;
        step();
        flush_i = 1'b0;
        check1("flush.busy_after", busy_o, 1'b0);
        check1("flush.valid_after", valid_o, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (valid_o) seen = 1'b1;
        end
        check1("flush.valid_never", seen, 1'b0);
        do_div(32'd9, 32'd3, 1'b0, 1'b0, 0, "after_flush_9_3");

        // Hold in DONE with ack low, and operand changes mid-BUSY.
        do_div(32'd50, 32'd5, 1'b0, 1'b0, 5, "hold_50_5");
        do_div(32'hFFFF_FF00, 32'd7, 1'b1, 1'b1, 0, "scramble");

        // Asynchronous reset in the middle of a BUSY phase (between edges).
        start_i  = 1'b1;
        signed_i = 1'b0;
        opa_i    = 32'd77;
        opb_i    = 32'd4;
        repeat (6) step();
        check1("midrst.busy_before", busy_o, 1'b1);
        #2;
        resetn  = 1'b0;
        start_i = 1'b0;
        #1;
        check1("midrst.busy", busy_o, 1'b0);
        check1("midrst.valid", valid_o, 1'b0);
        check1("midrst.stall", stall_o, 1'b0);
        check("midrst.hi", hi_o, '0);
        check("midrst.lo", lo_o, '0);
        step();
        resetn = 1'b1;
        step();

        // Randomized operations.
        for (int i = 0; i < 24; i++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) begin
                rb = '0;
            end else if (sel < 4) begin
                rb = $urandom_range(1, 255);
                if ($urandom_range(0, 1) == 1) rb = -rb;
            end else begin
                rb = $urandom;
            end
            rs = ($urandom_range(0, 1) == 1);
            do_div(ra, rb, rs, (i % 3) == 0, 0, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule
